// File: rtl/uram_bank_mem_pkg.sv
// mem_pckg: shared types, constants and helpers for the banked URAM store
//   rdw_mode_t    read-during-write policy of one bank
//   URAM_BYTE_WDT native URAM write lane (8 data bits + parity)
//   clog2_min1    $clog2 that never returns 0, so a one-bank store still has a select bit
package mem_pckg;
  typedef enum logic {RDW_WRITE_FIRST, RDW_READ_FIRST} rdw_mode_t;
  localparam int URAM_BYTE_WDT = 9;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uram_bank_mem_bank.sv
// uram_bank: one URAM array with per-lane write enables and a registered, RDW-aware read port
//   clk, rst_n  clock, asynchronous active-low reset (read register only; array is not reset)
//   wr_en_i     write strobe
//   wr_be_i     per-lane write enable
//   wr_addr_i   write address
//   wr_data_i   write data
//   rd_en_i     read strobe, loads the read register
//   rd_addr_i   read address
//   rd_data_o   registered read data, one cycle after rd_en_i
module uram_bank
  import mem_pckg::*;
#(
  parameter int        DATA_WDT = 72,
  parameter int        BYTE_WDT = URAM_BYTE_WDT,
  parameter int        ADDR_WDT = 12,
  parameter rdw_mode_t RDW_MODE = RDW_WRITE_FIRST,
  localparam int       BE_WDT   = DATA_WDT / BYTE_WDT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [BE_WDT-1:0]   wr_be_i,
  input  logic [ADDR_WDT-1:0] wr_addr_i,
  input  logic [DATA_WDT-1:0] wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_WDT-1:0] rd_addr_i,
  output logic [DATA_WDT-1:0] rd_data_o
);
  (* ram_style = "ultra" *) logic [DATA_WDT-1:0] mem_q [2**ADDR_WDT];
  logic [DATA_WDT-1:0] rd_merge, rd_data_d, rd_data_q;
  logic                coll;
  always_ff @(posedge clk) begin
    if (wr_en_i)
      for (int i = 0; i < BE_WDT; i++)
        if (wr_be_i[i]) mem_q[wr_addr_i][i*BYTE_WDT +: BYTE_WDT] <= wr_data_i[i*BYTE_WDT +: BYTE_WDT];
  end
  // Write-first view of the read word: enabled lanes come from the incoming write.
  always_comb begin
    rd_merge = mem_q[rd_addr_i];
    for (int i = 0; i < BE_WDT; i++)
      if (wr_be_i[i]) rd_merge[i*BYTE_WDT +: BYTE_WDT] = wr_data_i[i*BYTE_WDT +: BYTE_WDT];
  end
  assign coll      = wr_en_i && (wr_addr_i == rd_addr_i) && (RDW_MODE == RDW_WRITE_FIRST);
  assign rd_data_d = coll ? rd_merge : mem_q[rd_addr_i];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= rd_data_d;
  end
  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/uram_bank_mem.sv
// uram_bank_mem: banked byte-writable simple-dual-port URAM store with pipelined output
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en_i     write strobe
//   wr_be_i     per-lane write enable
//   wr_addr_i   {bank, bank_addr} write address
//   data_in_i   write data
//   rd_en_i     read strobe
//   rd_addr_i   {bank, bank_addr} read address
//   data_out_o  read data, '0 whenever rd_vld_o is low
//   rd_vld_o    read data valid, 1+PIPE_OUT_CNT cycles after rd_en_i
//   oob_err_o   sticky flag: some access named a bank >= NUM_BANKS
module uram_bank_mem
  import mem_pckg::*;
#(
  parameter int        DATA_WDT      = 72,
  parameter int        BYTE_WDT      = URAM_BYTE_WDT,
  parameter int        BANK_ADDR_WDT = 12,
  parameter int        NUM_BANKS     = 4,
  parameter int        PIPE_OUT_CNT  = 2,
  parameter rdw_mode_t RDW_MODE      = RDW_WRITE_FIRST,
  localparam int       BANK_SEL_WDT  = clog2_min1(NUM_BANKS),
  localparam int       ADDR_WDT      = BANK_SEL_WDT + BANK_ADDR_WDT,
  localparam int       BE_WDT        = DATA_WDT / BYTE_WDT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [BE_WDT-1:0]   wr_be_i,
  input  logic [ADDR_WDT-1:0] wr_addr_i,
  input  logic [DATA_WDT-1:0] data_in_i,
  input  logic                rd_en_i,
  input  logic [ADDR_WDT-1:0] rd_addr_i,
  output logic [DATA_WDT-1:0] data_out_o,
  output logic                rd_vld_o,
  output logic                oob_err_o
);
  if (DATA_WDT % BYTE_WDT != 0) begin : g_bad_wdt
    $error("DATA_WDT must be a multiple of BYTE_WDT");
  end
  if (NUM_BANKS < 1 || NUM_BANKS > 16) begin : g_bad_banks
    $error("NUM_BANKS must be in 1..16");
  end
  if (PIPE_OUT_CNT < 0 || PIPE_OUT_CNT > 4) begin : g_bad_pipe
    $error("PIPE_OUT_CNT must be in 0..4");
  end
  // One extra bit so the bank count itself is representable in the range compare.
  localparam logic [BANK_SEL_WDT:0] NB = (BANK_SEL_WDT+1)'(NUM_BANKS);
  logic [BANK_SEL_WDT-1:0] wr_bank, rd_bank, sel_q;
  logic                    wr_oob, rd_oob, vld_q, rd_oob_q, oob_err_d, oob_err_q;
  logic [DATA_WDT-1:0]     bank_rd [NUM_BANKS];
  logic [DATA_WDT-1:0]     mux_d, stg0_dat;
  assign wr_bank   = wr_addr_i[ADDR_WDT-1 -: BANK_SEL_WDT];
  assign rd_bank   = rd_addr_i[ADDR_WDT-1 -: BANK_SEL_WDT];
  assign wr_oob    = {1'b0, wr_bank} >= NB;
  assign rd_oob    = {1'b0, rd_bank} >= NB;
  assign oob_err_d = oob_err_q || (wr_en_i && wr_oob) || (rd_en_i && rd_oob);
  // An out-of-range bank matches no generated bank, so its write is dropped here.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    uram_bank #(
      .DATA_WDT (DATA_WDT),
      .BYTE_WDT (BYTE_WDT),
      .ADDR_WDT (BANK_ADDR_WDT),
      .RDW_MODE (RDW_MODE)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_en_i && (wr_bank == BANK_SEL_WDT'(b))),
      .wr_be_i   (wr_be_i),
      .wr_addr_i (wr_addr_i[BANK_ADDR_WDT-1:0]),
      .wr_data_i (data_in_i),
      .rd_en_i   (rd_en_i && (rd_bank == BANK_SEL_WDT'(b))),
      .rd_addr_i (rd_addr_i[BANK_ADDR_WDT-1:0]),
      .rd_data_o (bank_rd[b])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= 1'b0;
      sel_q     <= '0;
      rd_oob_q  <= 1'b0;
      oob_err_q <= 1'b0;
    end else begin
      vld_q     <= rd_en_i;
      sel_q     <= rd_bank;
      rd_oob_q  <= rd_oob;
      oob_err_q <= oob_err_d;
    end
  end
  always_comb begin
    mux_d = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (sel_q == BANK_SEL_WDT'(b)) mux_d = bank_rd[b];
  end
  // Stage 0 is gated so invalid slots and out-of-range reads carry zero data.
  assign stg0_dat = (vld_q && !rd_oob_q) ? mux_d : '0;
  if (PIPE_OUT_CNT == 0) begin : g_direct
    assign rd_vld_o   = vld_q;
    assign data_out_o = stg0_dat;
  end else begin : g_pipe
    logic [PIPE_OUT_CNT-1:0] pipe_vld_q;
    logic [DATA_WDT-1:0]     pipe_dat_q [PIPE_OUT_CNT];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_vld_q <= '0;
        for (int k = 0; k < PIPE_OUT_CNT; k++) pipe_dat_q[k] <= '0;
      end else begin
        pipe_vld_q[0] <= vld_q;
        pipe_dat_q[0] <= stg0_dat;
        for (int k = 1; k < PIPE_OUT_CNT; k++) begin
          pipe_vld_q[k] <= pipe_vld_q[k-1];
          pipe_dat_q[k] <= pipe_dat_q[k-1];
        end
      end
    end
    assign rd_vld_o   = pipe_vld_q[PIPE_OUT_CNT-1];
    assign data_out_o = pipe_dat_q[PIPE_OUT_CNT-1];
  end
  assign oob_err_o = oob_err_q;
endmodule

// File: tb/tb_uram_bank_mem.sv
// tb_uram_bank_mem: directed self-checking bench for uram_bank_mem
module tb_uram_bank_mem;
  import mem_pckg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0]  wr_be = '0;
  logic [13:0] wr_addr = '0, rd_addr = '0;
  logic [71:0] data_in = '0;
  logic        wr_en3 = 1'b0, rd_en3 = 1'b0;
  logic [7:0]  wr_be3 = '0;
  logic [12:0] wr_addr3 = '0, rd_addr3 = '0;
  logic [71:0] data_in3 = '0;
  logic [71:0] q [4];
  logic        v [4];
  logic        e [4];
  uram_bank_mem #(.NUM_BANKS(4), .PIPE_OUT_CNT(2), .RDW_MODE(RDW_WRITE_FIRST)) d0 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
    .data_in_i(data_in), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .data_out_o(q[0]), .rd_vld_o(v[0]), .oob_err_o(e[0]));
  uram_bank_mem #(.NUM_BANKS(4), .PIPE_OUT_CNT(2), .RDW_MODE(RDW_READ_FIRST)) d1 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
    .data_in_i(data_in), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .data_out_o(q[1]), .rd_vld_o(v[1]), .oob_err_o(e[1]));
  uram_bank_mem #(.NUM_BANKS(3), .PIPE_OUT_CNT(2), .RDW_MODE(RDW_WRITE_FIRST)) d2 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr),
    .data_in_i(data_in), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .data_out_o(q[2]), .rd_vld_o(v[2]), .oob_err_o(e[2]));
  uram_bank_mem #(.NUM_BANKS(1), .PIPE_OUT_CNT(0), .RDW_MODE(RDW_WRITE_FIRST)) d3 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en3), .wr_be_i(wr_be3), .wr_addr_i(wr_addr3),
    .data_in_i(data_in3), .rd_en_i(rd_en3), .rd_addr_i(rd_addr3),
    .data_out_o(q[3]), .rd_vld_o(v[3]), .oob_err_o(e[3]));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // single read on the shared port, checked on DUT d after the 3-cycle latency
  task automatic rd_chk(input int d, input logic [13:0] a, input logic [71:0] x, input string tag);
    rd_en = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    step();
    step();
    check({tag, "_vld"}, 72'(v[d]), 72'd1);
    check(tag, q[d], x);
    step();
    check({tag, "_vld_drop"}, 72'(v[d]), 72'd0);
    check({tag, "_dat_drop"}, q[d], 72'd0);
  endtask
  function automatic logic [71:0] merge(input logic [71:0] old, input logic [71:0] nw, input logic [7:0] be);
    merge = old;
    for (int i = 0; i < 8; i++) if (be[i]) merge[i*9 +: 9] = nw[i*9 +: 9];
  endfunction
  logic [71:0] exp0_q [$];
  int          iss0_q [$];
  bit          mon0 = 1'b0;
  always @(negedge clk) begin
    if (mon0 && v[0]) begin
      if (exp0_q.size() == 0) check("t1_extra_vld", 72'(v[0]), 72'd0);
      else begin
        check("t1_data", q[0], exp0_q.pop_front());
        check("t1_lat", 72'(cyc - iss0_q.pop_front()), 72'd3);
      end
    end
  end
  logic [71:0] mdl [16];
  logic [71:0] x;
  bit          oob_seen;
  initial begin
    step();
    for (int d = 0; d < 4; d++) begin
      check("rst_vld", 72'(v[d]), 72'd0);
      check("rst_dat", q[d], 72'd0);
      check("rst_oob", 72'(e[d]), 72'd0);
    end
    rst_n = 1'b1;
    step();
    // 1: fill and back-to-back readback
    wr_be = '1;
    for (int k = 0; k < 16384; k++) begin
      wr_en = 1'b1;
      wr_addr = 14'(k);
      data_in = 72'(k * 3);
      step();
    end
    wr_en = 1'b0;
    mon0 = 1'b1;
    for (int k = 0; k < 16384; k++) begin
      rd_en = 1'b1;
      rd_addr = 14'(k);
      exp0_q.push_back(72'(k * 3));
      iss0_q.push_back(cyc);
      step();
    end
    rd_en = 1'b0;
    repeat (5) step();
    mon0 = 1'b0;
    check("t1_drain", 72'(exp0_q.size()), 72'd0);
    // 2: byte enables
    wr_en = 1'b1; wr_be = '1; wr_addr = 14'h0005; data_in = '0;
    step();
    wr_be = 8'b0000_0101; data_in = '1;
    step();
    wr_en = 1'b0;
    rd_chk(0, 14'h0005, 72'h7FC01FF, "t2_be_wf");
    rd_chk(1, 14'h0005, 72'h7FC01FF, "t2_be_rf");
    // 3: read-during-write, full word
    wr_en = 1'b1; wr_be = '1; wr_addr = 14'h1010; data_in = 72'hAAA;
    step();
    data_in = 72'h555; rd_en = 1'b1; rd_addr = 14'h1010;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    step();
    check("t3_wf_vld", 72'(v[0]), 72'd1);
    check("t3_wf", q[0], 72'h555);
    check("t3_rf", q[1], 72'hAAA);
    step();
    rd_chk(0, 14'h1010, 72'h555, "t3_wf_after");
    rd_chk(1, 14'h1010, 72'h555, "t3_rf_after");
    // 3b: read-during-write, partial lanes
    wr_en = 1'b1; wr_be = '1; wr_addr = 14'h2020; data_in = '0;
    step();
    wr_be = 8'h81; data_in = '1; rd_en = 1'b1; rd_addr = 14'h2020;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    step();
    check("t3b_wf", q[0], 72'hFF_8000_0000_0000_01FF);
    check("t3b_rf", q[1], 72'd0);
    step();
    // 3c: same bank address in another bank does not interact
    wr_en = 1'b1; wr_be = '1; wr_addr = 14'h3020; data_in = '1; rd_en = 1'b1; rd_addr = 14'h2020;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    step();
    check("t3c_wf", q[0], 72'hFF_8000_0000_0000_01FF);
    check("t3c_rf", q[1], 72'hFF_8000_0000_0000_01FF);
    step();
    rd_chk(0, 14'h3020, '1, "t3c_other_bank");
    // 4: out-of-range bank on a 3-bank store
    rst_n = 1'b0;
    step();
    check("t4_oob_rst", 72'(e[2]), 72'd0);
    rst_n = 1'b1;
    step();
    check("t4_oob_idle", 72'(e[2]), 72'd0);
    wr_en = 1'b1; wr_be = '1; wr_addr = 14'h3050; data_in = '1;
    step();
    wr_en = 1'b0;
    check("t4_oob_wr", 72'(e[2]), 72'd1);
    rd_chk(2, 14'h3050, 72'd0, "t4_oob_rd");
    rd_chk(2, 14'h0050, 72'hF0, "t4_bank0");
    rd_chk(2, 14'h2050, 72'h60F0, "t4_bank2");
    check("t4_oob_sticky", 72'(e[2]), 72'd1);
    rst_n = 1'b0;
    #1;
    check("t4_oob_clr", 72'(e[2]), 72'd0);
    step();
    rst_n = 1'b1;
    step();
    rd_chk(2, 14'h3051, 72'd0, "t4_oob_rd_only");
    check("t4_oob_rd_flag", 72'(e[2]), 72'd1);
    // 5: reset while reads are in flight
    rd_en = 1'b1; rd_addr = 14'h0010;
    step();
    rd_addr = 14'h0011;
    step();
    rd_addr = 14'h0012; rst_n = 1'b0;
    step();
    rst_n = 1'b1; rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_vld", 72'(v[0]), 72'd0);
      check("t5_no_dat", q[0], 72'd0);
      step();
    end
    rd_chk(0, 14'h0010, 72'h30, "t5_kept0");
    rd_chk(0, 14'h0012, 72'h36, "t5_kept2");
    // 6: single bank, no output pipe, random traffic against a model
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 16; a++) begin
      wr_en3 = 1'b1; wr_be3 = '1; wr_addr3 = 13'(a);
      data_in3 = 72'({$urandom(), $urandom(), $urandom()});
      mdl[a] = data_in3;
      step();
    end
    wr_en3 = 1'b0;
    oob_seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      wr_en3 = 1'($urandom_range(0, 1));
      wr_be3 = 8'($urandom());
      wr_addr3 = {1'($urandom_range(0, 7) == 0), 8'd0, 4'($urandom())};
      data_in3 = 72'({$urandom(), $urandom(), $urandom()});
      rd_en3 = 1'($urandom_range(0, 2) != 0);
      rd_addr3 = {1'($urandom_range(0, 7) == 0), 8'd0, 4'($urandom())};
      if (rd_addr3[12]) x = '0;
      else if (wr_en3 && wr_addr3 == rd_addr3) x = merge(mdl[rd_addr3[3:0]], data_in3, wr_be3);
      else x = mdl[rd_addr3[3:0]];
      if (wr_en3 && !wr_addr3[12]) mdl[wr_addr3[3:0]] = merge(mdl[wr_addr3[3:0]], data_in3, wr_be3);
      oob_seen = oob_seen | (wr_en3 && wr_addr3[12]) | (rd_en3 && rd_addr3[12]);
      step();
      check("t6_vld", 72'(v[3]), 72'(rd_en3));
      check("t6_data", q[3], rd_en3 ? x : 72'd0);
    end
    wr_en3 = 1'b0; rd_en3 = 1'b0;
    step();
    check("t6_oob", 72'(e[3]), 72'(oob_seen));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
